mac_array_grid: RTL and testbench
=================================

# mac_array_grid

Parametrised ROWS×COLS multiply-accumulate array that succeeds the fixed 2×2 MAC array in the matrix datapath. It accepts a job of `k_len` operand beats over a valid/ready input stream, accumulates per-cell products in signed or unsigned saturating arithmetic, then drains the results one row per beat over a valid/ready output stream. It sits between the operand fetch logic and the result writeback buffer.

## Interface

- `ROWS`, 2: array rows.
- `COLS`, 2: array columns.
- `DATA_WIDTH`, 8: operand width.
- `ACC_WIDTH`, 20: accumulator width; must be ≥ 2*DATA_WIDTH.
- `RW`, derived, max(1, $clog2(ROWS)): row index width.

- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  job start pulse; sampled only in IDLE.
- `k_len`  in  16  beats per job; latched on accepted `start`.
- `signed_mode`  in  1  1 = two's-complement operands; latched on accepted `start`.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  array accepts a beat.
- `a_vec`  in  ROWS*COLS*DATA_WIDTH  A operand per cell; cell (r,c) at slice index r*COLS+c, cell 0 at LSB.
- `b_vec`  in  ROWS*COLS*DATA_WIDTH  B operand per cell, same packing.
- `out_valid`  out  1  result row valid.
- `out_ready`  in  1  consumer accepts a row.
- `out_row`  out  RW  index of the row on `out_data`.
- `out_data`  out  COLS*ACC_WIDTH  accumulators of row `out_row`, column 0 at LSB.
- `out_last`  out  1  high with the row ROWS-1 beat.
- `busy`  out  1  state ≠ IDLE.
- `sat_flag`  out  1  sticky: a clamp occurred in the current/last job.
- `done`  out  1  one-cycle pulse after the final drain handshake.

## Operation

- States: IDLE → ACCUM → FLUSH → DRAIN → IDLE.
- IDLE: `in_ready`=0, `out_valid`=0. `start` with `k_len`≠0 clears all accumulators, the product register and `sat_flag`, latches `k_len` and `signed_mode`, and moves the state to ACCUM. `start` with `k_len`=0 is ignored.
- `start` in any state other than IDLE is ignored. Changes to `signed_mode` or `k_len` mid-job have no effect.
- ACCUM: `in_ready`=1. A beat is accepted on `in_valid && in_ready`. The beat counter increments per accepted beat. When the `k_len`-th beat is accepted, the state moves to FLUSH and `in_ready` drops.
- Pipeline: the accepted beat's per-cell products are registered in the product register. On the following edge they are added into the accumulators, if that product register holds a valid entry.
- FLUSH: one cycle in which the last product is accumulated. The state then moves to DRAIN with row index 0.
- DRAIN: `out_valid`=1, `out_row`=row index, `out_data`=that row's accumulators. The row index advances on `out_valid && out_ready`. On the handshake at row ROWS-1 (`out_last`=1), the state moves to IDLE and `done` pulses.
- `out_row`, `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- Accumulators hold their values after the drain until the next accepted `start`.

Arithmetic:
- Unsigned mode: operands are zero-extended and the product is unsigned 2*DATA_WIDTH bits.
- Signed mode: operands are sign-extended, and the product is sign-extended to ACC_WIDTH.
- Every addition saturates. Unsigned range: [0, 2^ACC_WIDTH−1]. Signed range: [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- Any clamp in any cell sets `sat_flag`. A saturated accumulator keeps clamping on further overflow.

## Timing

- Reset values: all outputs 0, state IDLE, accumulators, product register and counters all 0.
- Reset asserted mid-job aborts immediately; no `done` pulse is produced.
- Accepted `start` at edge S: `busy`=1 and `in_ready`=1 from S onward.
- Beat accepted at edge E: the product is registered at E and accumulated at E+1.
- Last beat accepted at edge L: `in_ready`=0 after L; FLUSH runs L→L+1; `out_valid`=1 after L+1.
- With `out_ready` held high, rows 0..ROWS−1 drain on consecutive edges. `done`=1 for the cycle after the last handshake, and `busy`=0 in that same cycle.
- Minimum job length: 1 (start) + k_len + 1 (flush) + ROWS cycles.

## Test plan

- Reset and basic job: assert reset and check every output is 0. Then run an unsigned job with `k_len`=2.
  - Beat 1 per cell (00,01,10,11): (3,4),(4,5),(6,7),(8,9).
  - Beat 2: (5,6),(3,4),(5,6),(7,8).
  - Required drain: row0 `out_data`={32,42}, row1={128,72}.
  - Required flags: `out_last` on row1, `done` pulses once, `sat_flag`=0.
- Backpressure: repeat the basic job with `in_valid` low for 2 cycles between beats and `out_ready` low for 3 cycles on row0. Required: identical results, `out_data` stable while stalled, no beat lost or duplicated.
- Signed mode, `k_len`=1: cell00 a=0xFD, b=4 → 0xFFFF4 (−12); cell01 a=127, b=0x80 → −16256; `sat_flag`=0.
- Saturation, unsigned: 255×255 for `k_len`=16 → 1040400 with `sat_flag`=0; for `k_len`=17 → 1048575 with `sat_flag`=1.
- Saturation, signed: 0x80×0x80 for `k_len`=33 → 524287 with `sat_flag`=1.
- Control edge cases:
  - `start` with `k_len`=0 → `busy` stays 0.
  - `start` pulsed during ACCUM and during DRAIN → ignored, results unchanged.
  - `reset` asserted during ACCUM → all outputs 0 at once; the next job then gives the basic-job results.

Source files
------------

// File: rtl/mac_array_grid.sv
// ROWS x COLS multiply-accumulate array: accepts k_len operand beats, accumulates
// per-cell saturating products, then drains one row of accumulators per beat.
module mac_array_grid #(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     k_len,
  input  logic                            signed_mode,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] a_vec,
  input  logic [ROWS*COLS*DATA_WIDTH-1:0] b_vec,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RW-1:0]                   out_row,
  output logic [COLS*ACC_WIDTH-1:0]       out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            sat_flag,
  output logic                            done
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           k_q, k_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  sgn_q, sgn_d;
  logic                  prod_vld_q, prod_vld_d;
  logic                  sat_q, sat_d;
  logic                  done_q, done_d;
  logic [RW-1:0]         row_q, row_d;
  logic [ACC_WIDTH-1:0]  prod_q [N];
  logic [ACC_WIDTH-1:0]  prod_d [N];
  logic [ACC_WIDTH-1:0]  acc_q  [N];
  logic [ACC_WIDTH-1:0]  acc_d  [N];
  logic                  accept_s;
  logic                  drain_hs_s;
  logic                  last_row_s;
  logic [ACC_WIDTH:0]    add_s  [N];

  // Product of one cell, extended to accumulator width (sign-extended in signed mode).
  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b,
                                                   input logic               sgn);
    logic [2*DATA_WIDTH-1:0]        pu;
    logic signed [2*DATA_WIDTH-1:0] ps;
    logic [ACC_WIDTH-1:0]           r;
    pu = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    ps = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    if (sgn) begin
      r = ACC_WIDTH'(ps);
    end else begin
      r = ACC_WIDTH'(pu);
    end
    return r;
  endfunction

  // Saturating add; MSB of the result flags a clamp.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [ACC_WIDTH-1:0] p,
                                                 input logic                 sgn);
    logic [ACC_WIDTH:0] s;
    logic [ACC_WIDTH:0] r;
    if (sgn) begin
      s = {acc[ACC_WIDTH-1], acc} + {p[ACC_WIDTH-1], p};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
        r = {1'b1, s[ACC_WIDTH], {(ACC_WIDTH-1){~s[ACC_WIDTH]}}};
      end else begin
        r = {1'b0, s[ACC_WIDTH-1:0]};
      end
    end else begin
      s = {1'b0, acc} + {1'b0, p};
      if (s[ACC_WIDTH]) begin
        r = {1'b1, {ACC_WIDTH{1'b1}}};
      end else begin
        r = {1'b0, s[ACC_WIDTH-1:0]};
      end
    end
    return r;
  endfunction

  assign accept_s   = in_valid && (state_q == ACCUM);
  assign last_row_s = (row_q == RW'(ROWS - 1));
  assign drain_hs_s = (state_q == DRAIN) && out_ready;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    sgn_d      = sgn_q;
    sat_d      = sat_q;
    row_d      = row_q;
    done_d     = 1'b0;
    prod_vld_d = accept_s;
    for (int i = 0; i < N; i++) begin
      add_s[i] = sat_add(acc_q[i], prod_q[i], sgn_q);
      if (accept_s) begin
        prod_d[i] = mul_ext(a_vec[i*DATA_WIDTH +: DATA_WIDTH],
                            b_vec[i*DATA_WIDTH +: DATA_WIDTH], sgn_q);
      end else begin
        prod_d[i] = prod_q[i];
      end
      if (prod_vld_q) begin
        acc_d[i] = add_s[i][ACC_WIDTH-1:0];
        if (add_s[i][ACC_WIDTH]) begin
          sat_d = 1'b1;
        end else begin
          sat_d = sat_d;
        end
      end else begin
        acc_d[i] = acc_q[i];
      end
    end

    case (state_q)
      IDLE: begin
        if (start && (k_len != 16'd0)) begin
          state_d    = ACCUM;
          k_d        = k_len;
          sgn_d      = signed_mode;
          cnt_d      = 16'd0;
          sat_d      = 1'b0;
          prod_vld_d = 1'b0;
          for (int i = 0; i < N; i++) begin
            acc_d[i]  = '0;
            prod_d[i] = '0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s) begin
          cnt_d = cnt_q + 16'd1;
          if ((cnt_q + 16'd1) == k_q) begin
            state_d = FLUSH;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      FLUSH: begin
        state_d = DRAIN;
        row_d   = '0;
      end
      DRAIN: begin
        if (drain_hs_s) begin
          if (last_row_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= 16'd0;
      cnt_q      <= 16'd0;
      sgn_q      <= 1'b0;
      prod_vld_q <= 1'b0;
      sat_q      <= 1'b0;
      done_q     <= 1'b0;
      row_q      <= '0;
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      sgn_q      <= sgn_d;
      prod_vld_q <= prod_vld_d;
      sat_q      <= sat_d;
      done_q     <= done_d;
      row_q      <= row_d;
      for (int i = 0; i < N; i++) begin
        prod_q[i] <= prod_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  // Output row mux is driven only while draining so idle outputs read as zero.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++) begin
      if (state_q == DRAIN) begin
        out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[int'(row_q) * COLS + c];
      end else begin
        out_data[c*ACC_WIDTH +: ACC_WIDTH] = '0;
      end
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DRAIN);
  assign out_row   = (state_q == DRAIN) ? row_q : '0;
  assign out_last  = (state_q == DRAIN) && last_row_s;
  assign busy      = (state_q != IDLE);
  assign sat_flag  = sat_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mac_array_grid.sv
// Directed and randomized jobs against an arithmetic reference model of the MAC grid.
module tb_mac_array_grid;
  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 8;
  localparam int AW   = 20;
  localparam int RW   = 1;
  localparam int N    = ROWS * COLS;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [15:0]          k_len;
  logic                 signed_mode;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*DW-1:0]      a_vec;
  logic [N*DW-1:0]      b_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic [RW-1:0]        out_row;
  logic [COLS*AW-1:0]   out_data;
  logic                 out_last;
  logic                 busy;
  logic                 sat_flag;
  logic                 done;

  int errors = 0;
  int checks = 0;
  int ja [0:63][0:N-1];
  int jb [0:63][0:N-1];

  mac_array_grid #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .out_last(out_last), .busy(busy),
    .sat_flag(sat_flag), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " in_ready"},  64'(in_ready),  64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " out_row"},   64'(out_row),   64'd0);
    chk({tag, " out_data"},  64'(out_data),  64'd0);
    chk({tag, " out_last"},  64'(out_last),  64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
    chk({tag, " sat_flag"},  64'(sat_flag),  64'd0);
    chk({tag, " done"},      64'(done),      64'd0);
  endtask

  task automatic set_basic();
    ja[0][0] = 3; jb[0][0] = 4; ja[0][1] = 4; jb[0][1] = 5;
    ja[0][2] = 6; jb[0][2] = 7; ja[0][3] = 8; jb[0][3] = 9;
    ja[1][0] = 5; jb[1][0] = 6; ja[1][1] = 3; jb[1][1] = 4;
    ja[1][2] = 5; jb[1][2] = 6; ja[1][3] = 7; jb[1][3] = 8;
  endtask

  task automatic fill_all(input int k, input int a, input int b);
    for (int i = 0; i < k; i++)
      for (int c = 0; c < N; c++) begin
        ja[i][c] = a;
        jb[i][c] = b;
      end
  endtask

  task automatic run_job(input string tag, input int k, input bit sgn, input int gap,
                         input int ostall, input bit poke);
    longint acc [N];
    longint x, y, hi, lo;
    bit sat;
    logic [COLS*AW-1:0] exp_row;
    hi = sgn ? ((longint'(1) << (AW - 1)) - 1) : ((longint'(1) << AW) - 1);
    lo = sgn ? -(longint'(1) << (AW - 1)) : 0;
    sat = 1'b0;
    for (int c = 0; c < N; c++) acc[c] = 0;
    for (int i = 0; i < k; i++)
      for (int c = 0; c < N; c++) begin
        x = longint'(ja[i][c] & 255);
        y = longint'(jb[i][c] & 255);
        if (sgn && x > 127) x = x - 256;
        if (sgn && y > 127) y = y - 256;
        acc[c] = acc[c] + x * y;
        if (acc[c] > hi) begin acc[c] = hi; sat = 1'b1; end
        else if (acc[c] < lo) begin acc[c] = lo; sat = 1'b1; end
      end

    @(negedge clock);
    start = 1'b1; k_len = 16'(k); signed_mode = sgn;
    @(negedge clock);
    start = 1'b0; k_len = 16'($urandom); signed_mode = 1'($urandom);
    chk({tag, " busy after start"}, 64'(busy), 64'd1);
    chk({tag, " in_ready after start"}, 64'(in_ready), 64'd1);
    for (int i = 0; i < k; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0; a_vec = N*DW'($urandom); b_vec = N*DW'($urandom);
          @(negedge clock);
        end
      end
      in_valid = 1'b1;
      for (int c = 0; c < N; c++) begin
        a_vec[c*DW +: DW] = DW'(ja[i][c]);
        b_vec[c*DW +: DW] = DW'(jb[i][c]);
      end
      if (poke && i == 0) begin start = 1'b1; k_len = 16'd1; end
      @(negedge clock);
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk({tag, " in_ready in flush"}, 64'(in_ready), 64'd0);
    chk({tag, " out_valid in flush"}, 64'(out_valid), 64'd0);
    @(negedge clock);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) exp_row[c*AW +: AW] = AW'(acc[r*COLS + c]);
      for (int s = 0; s < ((r == 0) ? ostall : 0); s++) begin
        out_ready = 1'b0;
        if (poke) begin start = 1'b1; k_len = 16'd3; end
        chk({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, " stall out_row"}, 64'(out_row), 64'(r));
        chk({tag, " stall out_data"}, 64'(out_data), 64'(exp_row));
        @(negedge clock);
        start = 1'b0;
      end
      out_ready = 1'b1;
      chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " out_row"}, 64'(out_row), 64'(r));
      chk({tag, " out_data"}, 64'(out_data), 64'(exp_row));
      chk({tag, " out_last"}, 64'(out_last), 64'(r == ROWS - 1));
      chk({tag, " done early"}, 64'(done), 64'd0);
      @(negedge clock);
    end
    out_ready = 1'b0;
    chk({tag, " done pulse"}, 64'(done), 64'd1);
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    chk({tag, " out_valid at done"}, 64'(out_valid), 64'd0);
    chk({tag, " sat_flag"}, 64'(sat_flag), 64'(sat));
    @(negedge clock);
    chk({tag, " done single"}, 64'(done), 64'd0);
    chk({tag, " sat_flag sticky"}, 64'(sat_flag), 64'(sat));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; k_len = 16'd0; signed_mode = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a_vec = '0; b_vec = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    set_basic();
    run_job("basic", 2, 1'b0, 0, 0, 1'b0);
    run_job("backpressure", 2, 1'b0, 2, 3, 1'b0);
    run_job("start_ignored", 2, 1'b0, 1, 2, 1'b1);

    fill_all(1, 0, 0);
    ja[0][0] = 8'hFD; jb[0][0] = 4;
    ja[0][1] = 127;   jb[0][1] = 8'h80;
    run_job("signed", 1, 1'b1, 0, 0, 1'b0);

    fill_all(17, 255, 255);
    run_job("usat16", 16, 1'b0, 0, 0, 1'b0);
    run_job("usat17", 17, 1'b0, 0, 0, 1'b0);
    fill_all(33, 8'h80, 8'h80);
    run_job("ssat33", 33, 1'b1, 0, 0, 1'b0);

    @(negedge clock);
    start = 1'b1; k_len = 16'd0;
    @(negedge clock);
    start = 1'b0;
    chk("klen0 busy", 64'(busy), 64'd0);
    chk("klen0 in_ready", 64'(in_ready), 64'd0);

    set_basic();
    start = 1'b1; k_len = 16'd3; signed_mode = 1'b0;
    @(negedge clock);
    start = 1'b0; in_valid = 1'b1; a_vec = '1; b_vec = '1;
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    @(negedge clock);
    reset = 1'b0;
    chk("abort no done", 64'(done), 64'd0);
    run_job("after_abort", 2, 1'b0, 0, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      int k;
      k = int'($urandom_range(1, 8));
      for (int i = 0; i < k; i++)
        for (int c = 0; c < N; c++) begin
          ja[i][c] = int'($urandom_range(0, 255));
          jb[i][c] = int'($urandom_range(0, 255));
        end
      run_job("random", k, 1'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
